// File: rtl/ysyx_25030093_lsu_mem_resp_pkg.sv
// Shared definitions for the LSU memory responder: FSM states, LSU size
// codes and the LFSR feedback polynomial.
package ysyx_25030093_lsu_mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_TURN = 2'd3
  } state_e;

  // Access size codes, also used by the LSU
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // x^16 + x^14 + x^13 + x^11 + 1, as bit positions 15/13/12/10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_mem_resp_if.sv
// LSU request/response bundle. The LSU is the master, the memory the slave.
interface ysyx_25030093_lsu_mem_resp_if;

  logic        reqValid;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        respValid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output reqValid, addr, size, wen, wdata, wmask,
    input  respValid, rdata, err
  );

  modport slave (
    input  reqValid, addr, size, wen, wdata, wmask,
    output respValid, rdata, err
  );

endinterface

// File: rtl/ysyx_25030093_lfsr16.sv
// 16-bit Fibonacci LFSR used to jitter the response latency.
// A non-zero seed keeps it out of the all-zero lock-up state.
module ysyx_25030093_lfsr16
  import ysyx_25030093_lsu_mem_resp_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Reload the seed on reset, otherwise step once per enabled cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= lfsrNext(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ysyx_25030093_lsu_mem_resp.sv
// Default data memory of the NPC. Serves one LSU request at a time from a
// word-addressed RAM, with a fixed plus LFSR-randomised wait before replying.
module ysyx_25030093_lsu_mem_resp
  import ysyx_25030093_lsu_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned MIN_DELAY   = 1,
  parameter int unsigned RAND_BITS   = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_25030093_lsu_mem_resp_if.slave   lsu,
  output logic [31:0]                   req_count
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned MAX_CNT   = MIN_DELAY + (32'd1 << RAND_BITS) - 1;
  localparam int unsigned CNT_W     = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

  state_e             r_state;
  state_e             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntLoad;

  logic [31:0]        r_addr;
  logic [1:0]         r_size;
  logic               r_wen;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wmask;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_reqCount;

  logic [15:0]        w_lfsr;
  logic [31:0]        w_addr;
  logic [1:0]         w_size;
  logic               w_wen;
  logic [31:0]        w_wdata;
  logic [3:0]         w_wmask;
  logic [31:0]        w_off;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_enterResp;
  logic               w_inRange;
  logic               w_misaligned;
  logic               w_badSize;
  logic               w_err;
  logic               w_doWrite;

  logic [31:0]        r_mem [DEPTH_WORDS];

  ysyx_25030093_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  // Wait count for a new request: fixed part plus low LFSR bits
  assign w_cntLoad = CNT_W'(MIN_DELAY) + CNT_W'(w_lfsr & RAND_MASK);

  assign w_accept    = (r_state == ST_IDLE) && lsu.reqValid;
  assign w_enterResp = (w_accept && (w_cntLoad == '0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));

  // With zero latency the RAM is accessed on the accepting edge itself,
  // so the live request fields are used until they have been latched.
  assign w_addr  = (r_state == ST_IDLE) ? lsu.addr  : r_addr;
  assign w_size  = (r_state == ST_IDLE) ? lsu.size  : r_size;
  assign w_wen   = (r_state == ST_IDLE) ? lsu.wen   : r_wen;
  assign w_wdata = (r_state == ST_IDLE) ? lsu.wdata : r_wdata;
  assign w_wmask = (r_state == ST_IDLE) ? lsu.wmask : r_wmask;

  // Offset-based range test avoids overflow of BASE_ADDR + size
  assign w_off        = w_addr - BASE_ADDR;
  assign w_inRange    = (w_addr >= BASE_ADDR) && ((w_off >> 2) < 32'(DEPTH_WORDS));
  assign w_idx        = w_off[IDX_W+1:2];
  assign w_misaligned = (w_size == SZ_WORD) && (w_addr[1:0] != 2'b00);
  assign w_badSize    = (w_size != SZ_WORD) && (w_size != SZ_BYTE);
  assign w_err        = !w_inRange || w_misaligned || w_badSize;
  assign w_doWrite    = w_enterResp && !w_err && w_wen && (w_wmask != 4'b0000);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state: IDLE -> WAIT -> RESP -> TURN -> IDLE, skipping WAIT for zero wait
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (lsu.reqValid) begin
          w_nextState = (w_cntLoad == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: w_nextState = ST_TURN;
      ST_TURN: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request capture, wait countdown, response data and completion counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_size     <= SZ_BYTE;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_reqCount <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= lsu.addr;
        r_size  <= lsu.size;
        r_wen   <= lsu.wen;
        r_wdata <= lsu.wdata;
        r_wmask <= lsu.wmask;
        r_cnt   <= w_cntLoad;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_enterResp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_wen) ? 32'h0 : r_mem[w_idx];
      end
      if (r_state == ST_RESP) begin
        r_reqCount <= r_reqCount + 32'd1;
      end
    end
  end

  // Byte-lane RAM write; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (w_doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign lsu.respValid = (r_state == ST_RESP);
  assign lsu.rdata     = r_rdata;
  assign lsu.err       = r_err;
  assign req_count     = r_reqCount;

endmodule

// File: tb/tb_ysyx_25030093_lsu_mem_resp.sv
// Bench for the LSU memory responder: directed cases, latency checks on
// fixed-latency instances, reset abort, and 1000 random transactions
// scored against a behavioural memory model.
module tb_ysyx_25030093_lsu_mem_resp;

  localparam longint BASE  = 64'h8000_0000;
  localparam int     DEPTH = 1024;
  localparam int     MIN_A = 1;
  localparam int     RMAX_A = 3;

  logic        clock;
  logic        reset;
  logic [31:0] reqCountA;
  logic [31:0] reqCountB;
  logic [31:0] reqCountC;

  int          nChecks = 0;
  int          nFails  = 0;
  int          pulsesA = 0;
  int          expResp = 0;
  int          modelCount = 0;
  int          timeouts = 0;
  logic [31:0] lastRdata;
  logic [31:0] modelMem [DEPTH];

  ysyx_25030093_lsu_mem_resp_if lsuA ();
  ysyx_25030093_lsu_mem_resp_if lsuB ();
  ysyx_25030093_lsu_mem_resp_if lsuC ();

  ysyx_25030093_lsu_mem_resp dutA (
    .clock     (clock),
    .reset     (reset),
    .lsu       (lsuA),
    .req_count (reqCountA)
  );

  ysyx_25030093_lsu_mem_resp #(.MIN_DELAY(3), .RAND_BITS(0)) dutB (
    .clock     (clock),
    .reset     (reset),
    .lsu       (lsuB),
    .req_count (reqCountB)
  );

  ysyx_25030093_lsu_mem_resp #(.MIN_DELAY(0), .RAND_BITS(0)) dutC (
    .clock     (clock),
    .reset     (reset),
    .lsu       (lsuC),
    .req_count (reqCountC)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every response pulse of the main instance, sampled mid-cycle
  always @(negedge clock) begin
    if (lsuA.respValid === 1'b1) pulsesA++;
  end

  // Hard stop if something hangs beyond all bounded waits
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Behavioural memory: decide the outcome from the address map and size rules
  task automatic modelTxn(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          output logic expErr, output logic [31:0] expRdata);
    longint a;
    int     idx;
    bit     inRange, sizeOk, aligned;
    a       = longint'(addr);
    inRange = (a >= BASE) && (a < BASE + 4 * DEPTH);
    sizeOk  = (size == 2'b00) || (size == 2'b10);
    aligned = (size != 2'b10) || (a % 4 == 0);
    expErr  = !(inRange && sizeOk && aligned);
    expRdata = 32'h0;
    if (!expErr) begin
      idx = int'((a - BASE) / 4);
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) modelMem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        expRdata = modelMem[idx];
      end
    end
  endtask

  // Drive one request on the main instance like the LSU would, and scramble
  // the request fields once accepted to show they are latched
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               output bit ok, output int lat, output logic gotErr,
                               output logic [31:0] gotRdata);
    ok = 0; lat = -1; gotErr = 1'bx; gotRdata = 32'hx;
    @(negedge clock);
    lsuA.addr = addr; lsuA.size = size; lsuA.wen = wen;
    lsuA.wdata = wdata; lsuA.wmask = wmask; lsuA.reqValid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (lsuA.respValid === 1'b1) begin
        ok = 1; lat = k; gotErr = lsuA.err; gotRdata = lsuA.rdata;
        break;
      end
      if (k == 0) begin
        lsuA.addr = $urandom; lsuA.wdata = $urandom; lsuA.size = 2'($urandom);
        lsuA.wen = 1'($urandom); lsuA.wmask = 4'($urandom);
      end
    end
    @(negedge clock);
    lsuA.reqValid = 1'b0;
    @(negedge clock);
  endtask

  task automatic doTxn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                       input logic wen, input logic [31:0] wdata, input logic [3:0] wmask);
    logic        expErr, gotErr;
    logic [31:0] expRdata, gotRdata;
    int          lat;
    bit          ok;
    modelTxn(addr, size, wen, wdata, wmask, expErr, expRdata);
    applyStimulus(addr, size, wen, wdata, wmask, ok, lat, gotErr, gotRdata);
    checkOutput({tag, "_resp"}, 32'(ok), 32'd1);
    if (ok) begin
      expResp++;
      modelCount++;
      checkOutput({tag, "_err"}, 32'(gotErr), 32'(expErr));
      checkOutput({tag, "_rdata"}, gotRdata, expRdata);
      checkOutput({tag, "_lat"}, 32'((lat >= MIN_A) && (lat <= MIN_A + RMAX_A)), 32'd1);
    end else begin
      timeouts++;
    end
    lastRdata = gotRdata;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    lsuA.reqValid = 1'b0; lsuB.reqValid = 1'b0; lsuC.reqValid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelCount = 0;
  endtask

  // Address of one of a small pool of words, including the top two
  function automatic logic [31:0] poolAddr(input int p);
    int idx;
    idx = (p < 16) ? p : (DEPTH - 2 + (p - 16));
    return 32'(BASE + 4 * idx);
  endfunction

  initial begin
    int          latB, latC, k1, k2, pulsesBefore;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    reset = 1'b1;
    lsuA.reqValid = 1'b0; lsuA.addr = '0; lsuA.size = 2'b10; lsuA.wen = 1'b0;
    lsuA.wdata = '0; lsuA.wmask = '0;
    lsuB.reqValid = 1'b0; lsuB.addr = 32'h8000_0000; lsuB.size = 2'b10; lsuB.wen = 1'b0;
    lsuB.wdata = '0; lsuB.wmask = '0;
    lsuC.reqValid = 1'b0; lsuC.addr = 32'h8000_0004; lsuC.size = 2'b10; lsuC.wen = 1'b0;
    lsuC.wdata = '0; lsuC.wmask = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] reset state");
    checkOutput("rst_respValid", 32'(lsuA.respValid), 32'd0);
    checkOutput("rst_rdata", lsuA.rdata, 32'd0);
    checkOutput("rst_err", 32'(lsuA.err), 32'd0);
    checkOutput("rst_req_count", reqCountA, 32'd0);

    $display("[TB] fixed latency MIN_DELAY=3");
    @(negedge clock);
    lsuB.reqValid = 1'b1;
    latB = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (lsuB.respValid === 1'b1) begin latB = k; break; end
    end
    checkOutput("latB_err", 32'(lsuB.err), 32'd0);
    @(negedge clock);
    lsuB.reqValid = 1'b0;
    @(negedge clock);
    checkOutput("latB_cycles", 32'(latB), 32'd3);
    checkOutput("latB_req_count", reqCountB, 32'd1);

    $display("[TB] zero latency and back-to-back MIN_DELAY=0");
    @(negedge clock);
    lsuC.reqValid = 1'b1;
    latC = -1; k1 = -1; k2 = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (lsuC.respValid === 1'b1) begin
        if (k1 < 0) k1 = k;
        else begin k2 = k; break; end
      end
    end
    @(negedge clock);
    lsuC.reqValid = 1'b0;
    @(negedge clock);
    latC = k1;
    checkOutput("latC_cycles", 32'(latC), 32'd0);
    checkOutput("latC_b2b_gap", 32'(k2 - k1), 32'd3);
    checkOutput("latC_req_count", reqCountC, 32'd2);

    $display("[TB] directed stores and loads");
    doTxn("st_word", 32'h8000_0010, 2'b10, 1'b1, 32'hDEAD_BEEF, 4'b1111);
    doTxn("ld_word", 32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'b0000);
    checkOutput("ld_word_value", lastRdata, 32'hDEAD_BEEF);
    doTxn("st_byte", 32'h8000_0013, 2'b00, 1'b1, 32'hAB00_0000, 4'b1000);
    doTxn("ld_merge", 32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'b0000);
    checkOutput("byte_merge_value", lastRdata, 32'hABAD_BEEF);

    $display("[TB] error cases");
    doTxn("ld_below", 32'h7FFF_FFFC, 2'b10, 1'b0, 32'h0, 4'b0000);
    doTxn("ld_above", 32'h8000_1000, 2'b10, 1'b0, 32'h0, 4'b0000);
    doTxn("ld_misal", 32'h8000_0002, 2'b10, 1'b0, 32'h0, 4'b0000);
    doTxn("st_misal", 32'h8000_0012, 2'b10, 1'b1, 32'h1234_5678, 4'b1111);
    doTxn("st_badsz", 32'h8000_0010, 2'b01, 1'b1, 32'h0000_0000, 4'b1111);
    doTxn("st_nomask", 32'h8000_0010, 2'b00, 1'b1, 32'h5555_5555, 4'b0000);
    doTxn("ld_after_err", 32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'b0000);
    checkOutput("ram_unchanged", lastRdata, 32'hABAD_BEEF);
    checkOutput("req_count_directed", reqCountA, 32'(modelCount));

    $display("[TB] reset during wait aborts a store");
    doTxn("st_pre", 32'h8000_0020, 2'b10, 1'b1, 32'h1122_3344, 4'b1111);
    pulsesBefore = pulsesA;
    @(negedge clock);
    lsuA.addr = 32'h8000_0020; lsuA.size = 2'b10; lsuA.wen = 1'b1;
    lsuA.wdata = 32'h5566_7788; lsuA.wmask = 4'b1111; lsuA.reqValid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    lsuA.reqValid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    modelCount = 0;
    checkOutput("abort_no_pulse", 32'(pulsesA), 32'(pulsesBefore));
    checkOutput("abort_req_count", reqCountA, 32'd0);
    doTxn("ld_abort", 32'h8000_0020, 2'b10, 1'b0, 32'h0, 4'b0000);
    checkOutput("abort_old_data", lastRdata, 32'h1122_3344);

    $display("[TB] random transactions");
    for (int p = 0; p < 18; p++) begin
      doTxn("init", poolAddr(p), 2'b10, 1'b1, $urandom, 4'b1111);
    end
    doReset();
    for (int n = 0; n < 1000; n++) begin
      if (timeouts > 3) break;
      r = int'($urandom_range(0, 99));
      a = poolAddr(int'($urandom_range(0, 17)));
      if (r < 40) begin
        doTxn("rnd_ldw", a, 2'b10, 1'b0, $urandom, 4'($urandom));
      end else if (r < 70) begin
        doTxn("rnd_stw", a, 2'b10, 1'b1, $urandom, 4'($urandom));
      end else if (r < 80) begin
        doTxn("rnd_ldb", a + 32'($urandom_range(0, 3)), 2'b00, 1'b0, $urandom, 4'($urandom));
      end else if (r < 88) begin
        doTxn("rnd_stb", a + 32'($urandom_range(0, 3)), 2'b00, 1'b1, $urandom, 4'($urandom));
      end else if (r < 92) begin
        doTxn("rnd_low", 32'($urandom_range(0, 32'h7FFF_FFFF)) & ~32'h3, 2'b10,
              1'($urandom), $urandom, 4'b1111);
      end else if (r < 95) begin
        doTxn("rnd_high", 32'h8000_1000 + (32'($urandom_range(0, 32'h7FFF_EFFF)) & ~32'h3),
              2'b10, 1'($urandom), $urandom, 4'b1111);
      end else if (r < 97) begin
        doTxn("rnd_misal", a + 32'($urandom_range(1, 3)), 2'b10, 1'($urandom), $urandom, 4'b1111);
      end else begin
        sz = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
        doTxn("rnd_badsz", a + 32'($urandom_range(0, 3)), sz, 1'($urandom), $urandom, 4'($urandom));
      end
    end
    checkOutput("req_count_random", reqCountA, 32'd1000);
    checkOutput("pulse_count", 32'(pulsesA), 32'(expResp));

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
